sram_row_streamer: RTL and testbench
====================================

SRAM_ROW_STREAMER -- requirements
Module: sram_row_streamer

Interface
REQ-001 SHALL have parameter COUNT, default 128, meaning lanes (banks) per row.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning bits per lane.
REQ-003 SHALL have parameter HEIGHT, default 128, meaning rows in the attached array.
REQ-004 SHALL have parameter ADDR_BITS, default 7, meaning row address width; W = DATA_WIDTH*COUNT.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst_b, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, request to stream a block of rows.
REQ-008 SHALL have port base_addr, input, ADDR_BITS, first row address.
REQ-009 SHALL have port num_rows, input, ADDR_BITS+1, row count, 0..HEIGHT.
REQ-010 SHALL have port busy, output, 1, transfer in progress.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port mem_addr, output, ADDR_BITS, address to the SRAM array.
REQ-013 SHALL have port mem_en, output, 1, SRAM access enable.
REQ-014 SHALL have port mem_write_en, output, 1, SRAM write enable, constant 0.
REQ-015 SHALL have port mem_data_out, input, W, read data from the SRAM array.
REQ-016 SHALL have port row_data, output, W, streamed row.
REQ-017 SHALL have port row_idx, output, ADDR_BITS, SRAM address of row_data.
REQ-018 SHALL have port row_last, output, 1, marks the final row of the block.
REQ-019 SHALL have port row_valid, output, 1, row_data valid.
REQ-020 SHALL have port row_ready, input, 1, consumer accepts row.

Function
REQ-021 SHALL treat SRAM read latency as fixed: mem_data_out valid the cycle after mem_en=1 with mem_write_en=0.
REQ-022 SHALL implement FSM states IDLE, READ, DRAIN, DONE.
REQ-023 SHALL, in IDLE with start=1 and num_rows!=0, latch base_addr and num_rows, assert busy, and enter READ.
REQ-024 SHALL, in IDLE with start=1 and num_rows=0, enter DONE without any mem_en.
REQ-025 SHALL ignore start outside IDLE.
REQ-026 SHALL, in READ, issue one read per cycle when credit allows, at addresses base, base+1, ..., wrapping from HEIGHT-1 to 0.
REQ-027 SHALL hold a 2-entry output FIFO; a read is issued only when occupancy + in-flight reads - (pop this cycle) <= 1.
REQ-028 SHALL capture mem_data_out into the FIFO on the edge ending its valid cycle, tagged with its address and last flag.
REQ-029 SHALL present the FIFO head on row_data/row_idx/row_last with row_valid=1 whenever the FIFO is non-empty.
REQ-030 SHALL pop the head on row_valid & row_ready; row_data SHALL stay stable while row_valid=1 and row_ready=0.
REQ-031 SHALL enter DRAIN after the last read is issued; DONE after the row_last beat is accepted.
REQ-032 SHALL assert done for exactly one cycle in DONE, deassert busy in that same cycle, and then return to IDLE.
REQ-033 SHALL achieve row_valid 3 cycles after start is sampled (mem_en in cycle +1, capture at edge +2).
REQ-034 SHALL sustain one row per cycle while row_ready is held high.
REQ-035 SHALL drive mem_en=0 and hold mem_addr at its last value when no read is issued.
REQ-036 SHALL never overflow the FIFO or drop a captured row, whatever the row_ready pattern.

Reset
REQ-037 SHALL, on rst_b=0, asynchronously enter IDLE and empty the FIFO and in-flight tracking.
REQ-038 SHALL, under reset, hold busy, done, mem_en, mem_write_en, row_valid, row_last = 0 and mem_addr, row_idx, row_data = 0.
REQ-039 SHALL, on reset mid-transfer, discard all rows; no done pulse follows.

Verification
REQ-040 SHALL cover: base=5, num_rows=4, ready=1 -> mem_en on 4 consecutive cycles at addr 5..8; row_idx 5..8 on 4 consecutive cycles; row_last on 8; done one cycle after.
REQ-041 SHALL cover: base=126, num_rows=4 -> row_idx 126, 127, 0, 1.
REQ-042 SHALL cover: num_rows=3, ready low for 10 cycles -> at most 2 reads issued; row_data stable; all 3 rows are delivered in order once ready rises.
REQ-043 SHALL cover: num_rows=0 -> no mem_en; done one cycle after start; no row_valid.
REQ-044 SHALL cover: start pulsed while busy -> ignored; the row count is unchanged.
REQ-045 SHALL cover: rst_b low after 2 rows of 6 -> all outputs 0 at once; no done; a fresh start then runs normally.

Source files
------------

// File: rtl/sram_row_streamer.sv
// Streams a block of rows from a 1-cycle-latency SRAM through a 2-entry FIFO.
// Ports: start/base_addr/num_rows in; busy/done; mem_* SRAM side; row_* valid/ready stream out.
module sram_row_streamer #(
  parameter int COUNT      = 128,
  parameter int DATA_WIDTH = 16,
  parameter int HEIGHT     = 128,
  parameter int ADDR_BITS  = 7
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic                          start,
  input  logic [ADDR_BITS-1:0]          base_addr,
  input  logic [ADDR_BITS:0]            num_rows,
  output logic                          busy,
  output logic                          done,
  output logic [ADDR_BITS-1:0]          mem_addr,
  output logic                          mem_en,
  output logic                          mem_write_en,
  input  logic [DATA_WIDTH*COUNT-1:0]   mem_data_out,
  output logic [DATA_WIDTH*COUNT-1:0]   row_data,
  output logic [ADDR_BITS-1:0]          row_idx,
  output logic                          row_last,
  output logic                          row_valid,
  input  logic                          row_ready
);

  localparam int W = DATA_WIDTH * COUNT;
  localparam logic [ADDR_BITS-1:0] TOP_ROW = ADDR_BITS'(HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [ADDR_BITS-1:0] next_addr;
  logic [ADDR_BITS-1:0] last_addr;
  logic [ADDR_BITS:0]   remaining;
  logic                 infl;
  logic [ADDR_BITS-1:0] infl_addr;
  logic                 infl_last;
  logic [1:0]           count;
  logic [W-1:0]         d0, d1;
  logic [ADDR_BITS-1:0] i0, i1;
  logic                 l0, l1;

  logic       pop;
  logic       issue;
  logic       is_last;
  logic       go;
  logic [2:0] occ;

  assign row_valid    = (count != 2'd0);
  assign pop          = row_valid & row_ready;
  assign is_last      = (remaining == {{ADDR_BITS{1'b0}}, 1'b1});
  assign go           = (state == IDLE) && start && (num_rows != '0);

  // Projected occupancy at the end of this cycle; a new read lands one
  // cycle later, so it may only go out while this stays at most one.
  assign occ   = {1'b0, count} + {2'b0, infl} - {2'b0, pop};
  assign issue = (state == READ) && (occ <= 3'd1);

  assign mem_en       = issue;
  assign mem_write_en = 1'b0;
  assign mem_addr     = issue ? next_addr : last_addr;
  assign row_data     = d0;
  assign row_idx      = i0;
  assign row_last     = l0 & row_valid;

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = (num_rows == '0) ? DONE : READ;
      end
      READ: begin
        busy = 1'b1;
        if (issue && is_last) state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (pop && l0) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      next_addr <= '0;
      last_addr <= '0;
      remaining <= '0;
      infl      <= 1'b0;
      infl_addr <= '0;
      infl_last <= 1'b0;
    end else begin
      infl <= issue;
      if (go) begin
        next_addr <= base_addr;
        remaining <= num_rows;
      end else if (issue) begin
        next_addr <= (next_addr == TOP_ROW) ? '0 : next_addr + 1'b1;
        remaining <= remaining - 1'b1;
        last_addr <= next_addr;
        infl_addr <= next_addr;
        infl_last <= is_last;
      end
    end
  end

  // Head always lives in slot 0 so row_data only moves on a pop.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      count <= 2'd0;
      d0    <= '0;
      d1    <= '0;
      i0    <= '0;
      i1    <= '0;
      l0    <= 1'b0;
      l1    <= 1'b0;
    end else begin
      unique case ({infl, pop})
        2'b10: begin
          if (count == 2'd0) begin
            d0 <= mem_data_out;
            i0 <= infl_addr;
            l0 <= infl_last;
          end else begin
            d1 <= mem_data_out;
            i1 <= infl_addr;
            l1 <= infl_last;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          d0    <= d1;
          i0    <= i1;
          l0    <= l1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            d0 <= mem_data_out;
            i0 <= infl_addr;
            l0 <= infl_last;
          end else begin
            d0 <= d1;
            i0 <= i1;
            l0 <= l1;
            d1 <= mem_data_out;
            i1 <= infl_addr;
            l1 <= infl_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_row_streamer.sv
// Bench for sram_row_streamer: SRAM model, row queue reference, directed and random runs.
// Drives start/ready, checks timing signatures, row order/data, stability and reset.
module tb_sram_row_streamer;

  localparam int H  = 128;
  localparam int AB = 7;
  localparam int W  = 16 * 128;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          start;
  logic [AB-1:0] base_addr;
  logic [AB:0]   num_rows;
  logic          busy, done;
  logic [AB-1:0] mem_addr;
  logic          mem_en, mem_write_en;
  logic [W-1:0]  mem_data_out = '0;
  logic [W-1:0]  row_data;
  logic [AB-1:0] row_idx;
  logic          row_last, row_valid;
  logic          row_ready;

  sram_row_streamer dut (
    .clk(clk), .rst_b(rst_b), .start(start),
    .base_addr(base_addr), .num_rows(num_rows),
    .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_en(mem_en),
    .mem_write_en(mem_write_en), .mem_data_out(mem_data_out),
    .row_data(row_data), .row_idx(row_idx),
    .row_last(row_last), .row_valid(row_valid),
    .row_ready(row_ready)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [H];

  // Read data appears the cycle after the request; otherwise garbage.
  always @(posedge clk) begin
    if (mem_en && !mem_write_en) mem_data_out <= mem[mem_addr];
    else                         mem_data_out <= ~mem_data_out;
  end

  typedef struct {
    logic [AB-1:0] idx;
    logic [W-1:0]  data;
    logic          last;
  } row_t;

  row_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int reads = 0;
  int acc   = 0;
  int dones = 0;
  int outst = 0;
  int maxout = 0;
  int last_m = 0;

  logic          stall_prev = 1'b0;
  logic [W-1:0]  prev_data;
  logic [AB-1:0] prev_idx;
  logic          prev_last;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs,
                      input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed[63:0]=%0h expected[63:0]=%0h",
             tag, obs[63:0], exp[63:0]);
    end
  endtask

  task automatic push_exp(input int b, input int n);
    row_t r;
    for (int i = 0; i < n; i++) begin
      r.idx  = AB'((b + i) % H);
      r.data = mem[(b + i) % H];
      r.last = (i == n - 1);
      exp_q.push_back(r);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_b) begin
      stall_prev = 1'b0;
      outst      = 0;
    end else begin
      chk("write_en_low", mem_write_en, 0);
      if (outst > maxout) maxout = outst;
      if (stall_prev && row_valid) begin
        chkw("stall_data", row_data, prev_data);
        chk("stall_idx", row_idx, prev_idx);
        chk("stall_last", row_last, prev_last);
      end
      if (mem_en) begin
        reads++;
        outst++;
      end
      if (done) dones++;
      if (row_valid && row_ready) begin
        acc++;
        outst--;
        if (exp_q.size() == 0) begin
          chk("extra_row", 1, 0);
        end else begin
          row_t r;
          r = exp_q.pop_front();
          chk("row_idx", row_idx, r.idx);
          chkw("row_data", row_data, r.data);
          chk("row_last", row_last, r.last);
        end
      end
      stall_prev = row_valid && !row_ready;
      prev_data  = row_data;
      prev_idx   = row_idx;
      prev_last  = row_last;
    end
  end

  task automatic do_start(input int b, input int n, input bit model);
    @(posedge clk);
    #1;
    base_addr = AB'(b);
    num_rows  = (AB + 1)'(n);
    start     = 1'b1;
    if (model) push_exp(b, n);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Cycle-by-cycle signature with ready held high.
  task automatic run_timed(input string tag, input int b, input int n);
    logic [31:0] o, e;
    int j;
    row_ready = 1'b1;
    do_start(b, n, 1'b1);
    for (int k = 1; k <= n + 5; k++) begin
      @(negedge clk);
      o = {13'd0, mem_en, mem_addr, row_valid,
           row_valid ? row_idx : 7'd0, row_valid & row_last, done, busy};
      j = (k < n) ? k : n;
      e = {13'd0,
           1'(n > 0 && k <= n),
           AB'(n > 0 ? (b + j - 1) % H : last_m),
           1'(n > 0 && k >= 3 && k <= n + 2),
           AB'((n > 0 && k >= 3 && k <= n + 2) ? (b + k - 3) % H : 0),
           1'(n > 0 && k == n + 2),
           1'(n > 0 ? k == n + 3 : k == 1),
           1'(n > 0 && k <= n + 2)};
      chk($sformatf("%s_cyc%0d", tag, k), o, e);
    end
    if (n > 0) last_m = (b + n - 1) % H;
    chk({tag, "_q_empty"}, exp_q.size(), 0);
  endtask

  task automatic wait_done(input string tag, input int lim, input bit rnd);
    int d0 = dones;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk);
      #1;
      if (rnd) row_ready = ($urandom % 10) < 6;
      if (dones != d0) break;
    end
    chk({tag, "_done"}, dones - d0, 1);
  endtask

  initial begin
    int r0, a0, d0, b, n;
    rst_b     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    num_rows  = '0;
    row_ready = 1'b0;
    for (int r = 0; r < H; r++)
      for (int w = 0; w < W / 32; w++)
        mem[r][32*w +: 32] = $urandom;

    #22;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_wen", mem_write_en, 0);
    chk("rst_valid", row_valid, 0);
    chk("rst_last", row_last, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_idx", row_idx, 0);
    chkw("rst_data", row_data, '0);
    @(negedge clk);
    #2 rst_b = 1'b1;

    run_timed("b5n4", 5, 4);
    run_timed("wrap", 126, 4);
    run_timed("n0", 33, 0);
    run_timed("n1", 127, 1);

    row_ready = 1'b0;
    r0 = reads;
    a0 = acc;
    do_start(40, 3, 1'b1);
    for (int i = 0; i < 9; i++) @(posedge clk);
    #1;
    chk("stall_reads", reads - r0, 2);
    chk("stall_valid", row_valid, 1);
    chk("stall_head", row_idx, 40);
    row_ready = 1'b1;
    wait_done("stall", 50, 1'b0);
    chk("stall_acc", acc - a0, 3);
    chk("stall_q", exp_q.size(), 0);
    last_m = 42;

    r0 = reads;
    a0 = acc;
    do_start(70, 5, 1'b1);
    @(posedge clk);
    #1;
    base_addr = 7'd10;
    num_rows  = 8'd2;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("busy_start", 50, 1'b0);
    chk("busy_start_acc", acc - a0, 5);
    chk("busy_start_reads", reads - r0, 5);
    chk("busy_start_q", exp_q.size(), 0);
    last_m = 74;

    a0 = acc;
    do_start(20, 6, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (acc - a0 >= 2) break;
    end
    chk("mid_two_rows", acc - a0, 2);
    d0 = dones;
    #3 rst_b = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_valid", row_valid, 0);
    chk("mid_mem_en", mem_en, 0);
    chk("mid_addr", mem_addr, 0);
    chk("mid_idx", row_idx, 0);
    chk("mid_last", row_last, 0);
    chkw("mid_data", row_data, '0);
    exp_q.delete();
    last_m = 0;
    repeat (3) @(negedge clk);
    #2 rst_b = 1'b1;
    repeat (4) @(posedge clk);
    chk("mid_no_done", dones - d0, 0);
    run_timed("fresh", 9, 3);

    maxout = 0;
    for (int t = 0; t < 8; t++) begin
      b  = $urandom % H;
      n  = $urandom_range(1, 20);
      a0 = acc;
      row_ready = 1'b0;
      do_start(b, n, 1'b1);
      wait_done($sformatf("rnd%0d", t), 500, 1'b1);
      chk($sformatf("rnd%0d_acc", t), acc - a0, n);
      chk($sformatf("rnd%0d_q", t), exp_q.size(), 0);
    end
    chk("max_outstanding", maxout <= 2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
